// File: rtl/key_press_detector_if.sv
// Key-press detector signal bundle: raw level and clear toward the detector,
// debounced pulse/level/count back out.
interface key_press_detector_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   In;
  logic                   Clear;
  logic                   Press;
  logic                   Held;
  logic [COUNT_WIDTH-1:0] PressCount;

  modport master (
    output In,
    output Clear,
    input  Press,
    input  Held,
    input  PressCount
  );

  modport slave (
    input  In,
    input  Clear,
    output Press,
    output Held,
    output PressCount
  );
endinterface

// File: rtl/key_press_detector.sv
// Debounces a synchronized key level and emits one Press pulse per accepted press.
// Press fires the cycle after the DEBOUNCE_CYCLES-th high sample; no backpressure.
module key_press_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 8
) (
  input logic             Clock,
  input logic             Reset,
  key_press_detector_if.slave kp
);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESSED,
    RELEASING
  } state_t;

  localparam logic [7:0]             CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t                 state;
  logic [7:0]             cnt;
  logic                   press_q;
  logic                   held_q;
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      press_q <= 1'b0;
      held_q  <= 1'b0;
      count_q <= '0;
    end else begin
      press_q <= 1'b0;

      case (state)
        IDLE: begin
          if (kp.In) begin
            state <= ARMING;
            cnt   <= 8'd1;
          end else begin
            cnt   <= 8'd0;
          end
        end

        ARMING: begin
          if (!kp.In) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            cnt     <= 8'd0;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        PRESSED: begin
          if (!kp.In) begin
            state <= RELEASING;
            cnt   <= 8'd1;
          end
        end

        RELEASING: begin
          // A bounce back high resumes the held press without a new pulse.
          if (kp.In) begin
            state <= PRESSED;
            cnt   <= 8'd0;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            held_q <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= 8'd0;
          held_q <= 1'b0;
        end
      endcase

      // Clear has priority over a same-edge increment; count saturates at all-ones.
      if (kp.Clear) begin
        count_q <= '0;
      end else if (state == ARMING && kp.In && cnt == CNT_LAST && count_q != COUNT_MAX) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign kp.Press      = press_q;
  assign kp.Held       = held_q;
  assign kp.PressCount = count_q;

  a_press_single: assert property (@(posedge Clock) disable iff (Reset) press_q |=> !press_q);
  a_held_state:   assert property (@(posedge Clock) disable iff (Reset)
                                   held_q == (state == PRESSED || state == RELEASING));

endmodule

// File: tb/tb_key_press_detector.sv
// Directed-vector bench for key_press_detector with DEBOUNCE_CYCLES=4, COUNT_WIDTH=8.
module tb_key_press_detector;

  logic Clock = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  key_press_detector_if #(.COUNT_WIDTH(8)) kif ();

  key_press_detector #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH    (8)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .kp   (kif.slave)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    kif.In   = 1'b0;
    kif.Clear = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    kif.In    = 1'b0;
    kif.Clear = 1'b0;
    #2;
    checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL reset_press: got %0b expected 0", kif.Press); end
    checks++; if (kif.Held !== 1'b0) begin errors++; $display("FAIL reset_held: got %0b expected 0", kif.Held); end
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", kif.PressCount); end
    kif.In    = 1'b1;
    kif.Clear = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL reset_hold_press cyc%0d: got %0b expected 0", i, kif.Press); end
      checks++; if (kif.Held !== 1'b0) begin errors++; $display("FAIL reset_hold_held cyc%0d: got %0b expected 0", i, kif.Held); end
    end
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL reset_hold_count: got %0d expected 0", kif.PressCount); end
    Reset     = 1'b0;
    kif.In    = 1'b0;
    kif.Clear = 1'b0;
    tick();
    checks++; if (kif.Held !== 1'b0) begin errors++; $display("FAIL post_reset_held: got %0b expected 0", kif.Held); end
  endtask

  task automatic test_single_press();
    for (int i = 1; i <= 10; i++) begin
      kif.In = 1'b1;
      tick();
      checks++; if (kif.Press !== (i == 4)) begin errors++; $display("FAIL single_press cyc%0d: got %0b expected %0b", i, kif.Press, (i == 4)); end
      checks++; if (kif.Held !== (i >= 4)) begin errors++; $display("FAIL single_held cyc%0d: got %0b expected %0b", i, kif.Held, (i >= 4)); end
    end
    checks++; if (kif.PressCount !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", kif.PressCount); end
    for (int i = 1; i <= 4; i++) begin
      kif.In = 1'b0;
      tick();
      checks++; if (kif.Held !== (i < 4)) begin errors++; $display("FAIL single_release_held cyc%0d: got %0b expected %0b", i, kif.Held, (i < 4)); end
      checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL single_release_press cyc%0d: got %0b expected 0", i, kif.Press); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) begin
        kif.In = (j != 3);
        tick();
        checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL glitch_press r%0d j%0d: got %0b expected 0", r, j, kif.Press); end
        checks++; if (kif.Held !== 1'b0) begin errors++; $display("FAIL glitch_held r%0d j%0d: got %0b expected 0", r, j, kif.Held); end
      end
    end
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", kif.PressCount); end
  endtask

  task automatic test_release_glitch();
    kif.In = 1'b1;
    repeat (4) tick();
    checks++; if (kif.Press !== 1'b1) begin errors++; $display("FAIL rglitch_press: got %0b expected 1", kif.Press); end
    for (int i = 1; i <= 2; i++) begin
      kif.In = 1'b0;
      tick();
      checks++; if (kif.Held !== 1'b1) begin errors++; $display("FAIL rglitch_low_held cyc%0d: got %0b expected 1", i, kif.Held); end
    end
    for (int i = 1; i <= 5; i++) begin
      kif.In = 1'b1;
      tick();
      checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL rglitch_repress cyc%0d: got %0b expected 0", i, kif.Press); end
      checks++; if (kif.Held !== 1'b1) begin errors++; $display("FAIL rglitch_held cyc%0d: got %0b expected 1", i, kif.Held); end
    end
    for (int i = 1; i <= 4; i++) begin
      kif.In = 1'b0;
      tick();
      checks++; if (kif.Held !== (i < 4)) begin errors++; $display("FAIL rglitch_release_held cyc%0d: got %0b expected %0b", i, kif.Held, (i < 4)); end
    end
    checks++; if (kif.PressCount !== 8'd1) begin errors++; $display("FAIL rglitch_count: got %0d expected 1", kif.PressCount); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      kif.In = 1'b1;
      repeat (4) tick();
      checks++; if (kif.Press !== 1'b1) begin errors++; $display("FAIL sat_press k%0d: got %0b expected 1", k, kif.Press); end
      checks++; if (kif.PressCount !== ((k > 255) ? 8'd255 : 8'(k))) begin
        errors++; $display("FAIL sat_count k%0d: got %0d expected %0d", k, kif.PressCount, (k > 255) ? 255 : k);
      end
      if (k < 256) begin
        kif.In = 1'b0;
        repeat (4) tick();
      end
    end
    kif.Clear = 1'b1;
    tick();
    kif.Clear = 1'b0;
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL sat_clear_count: got %0d expected 0", kif.PressCount); end
    checks++; if (kif.Held !== 1'b1) begin errors++; $display("FAIL sat_clear_held: got %0b expected 1", kif.Held); end
    checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL sat_clear_press: got %0b expected 0", kif.Press); end
    tick();
    checks++; if (kif.Held !== 1'b1) begin errors++; $display("FAIL sat_after_clear_held: got %0b expected 1", kif.Held); end
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL sat_after_clear_count: got %0d expected 0", kif.PressCount); end
    for (int i = 1; i <= 4; i++) begin
      kif.In = 1'b0;
      tick();
      checks++; if (kif.Held !== (i < 4)) begin errors++; $display("FAIL sat_release_held cyc%0d: got %0b expected %0b", i, kif.Held, (i < 4)); end
    end
  endtask

  task automatic test_clear_collision();
    kif.In = 1'b1;
    repeat (4) tick();
    checks++; if (kif.PressCount !== 8'd1) begin errors++; $display("FAIL coll_pre_count: got %0d expected 1", kif.PressCount); end
    kif.In = 1'b0;
    repeat (4) tick();
    kif.In = 1'b1;
    repeat (3) tick();
    kif.Clear = 1'b1;
    tick();
    kif.Clear = 1'b0;
    checks++; if (kif.Press !== 1'b1) begin errors++; $display("FAIL coll_press: got %0b expected 1", kif.Press); end
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL coll_count: got %0d expected 0", kif.PressCount); end
    checks++; if (kif.Held !== 1'b1) begin errors++; $display("FAIL coll_held: got %0b expected 1", kif.Held); end
    tick();
    checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL coll_after_press: got %0b expected 0", kif.Press); end
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL coll_after_count: got %0d expected 0", kif.PressCount); end
    kif.In = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    kif.In = 1'b1;
    repeat (4) tick();
    checks++; if (kif.PressCount !== 8'd1) begin errors++; $display("FAIL areset_pre_count: got %0d expected 1", kif.PressCount); end
    tick();
    checks++; if (kif.Held !== 1'b1) begin errors++; $display("FAIL areset_pre_held: got %0b expected 1", kif.Held); end
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (kif.Press !== 1'b0) begin errors++; $display("FAIL areset_press: got %0b expected 0", kif.Press); end
    checks++; if (kif.Held !== 1'b0) begin errors++; $display("FAIL areset_held: got %0b expected 0", kif.Held); end
    checks++; if (kif.PressCount !== 8'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", kif.PressCount); end
    #2;
    Reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (kif.Press !== (i == 4)) begin errors++; $display("FAIL areset_repress cyc%0d: got %0b expected %0b", i, kif.Press, (i == 4)); end
      checks++; if (kif.Held !== (i >= 4)) begin errors++; $display("FAIL areset_reheld cyc%0d: got %0b expected %0b", i, kif.Held, (i >= 4)); end
    end
    checks++; if (kif.PressCount !== 8'd1) begin errors++; $display("FAIL areset_recount: got %0d expected 1", kif.PressCount); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_release_glitch();
    test_saturation();
    test_clear_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
